// File: rtl/signed_step_counter.sv
// Registered two's-complement up/down counter with a programmable step.
// Overflow either wraps modulo 2^Width or clamps to the signed limits, chosen by Sat.
module signed_step_counter #(
  parameter int unsigned Width = 6,
  parameter bit          Sat   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  input  logic             up_dn_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] q_o,
  output logic             ovf_o,
  output logic             ovf_sticky_o,
  output logic             zero_o,
  output logic             neg_o
);

  if (Width < 2) begin : gen_width_check
    $error("signed_step_counter: Width must be at least 2");
  end

  // Two guard bits hold any q +/- unsigned step without losing the true sign.
  localparam int unsigned SumW = Width + 2;
  localparam logic signed [SumW-1:0] MaxVal = {3'b000, {(Width-1){1'b1}}};
  localparam logic signed [SumW-1:0] MinVal = {3'b111, {(Width-1){1'b0}}};

  logic [Width-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

  logic signed [SumW-1:0] q_ext;
  logic signed [SumW-1:0] step_ext;
  logic signed [SumW-1:0] sum;
  logic                   above;
  logic                   below;

  always_comb begin
    q_ext    = {{2{q_q[Width-1]}}, q_q};
    step_ext = {2'b00, step_i};
    sum      = up_dn_i ? (q_ext + step_ext) : (q_ext - step_ext);
    above    = sum > MaxVal;
    below    = sum < MinVal;
  end

  always_comb begin
    q_d      = q_q;
    ovf_d    = 1'b0;
    sticky_d = sticky_q;
    if (load_i) begin
      q_d      = d_i;
      sticky_d = 1'b0;
    end else if (en_i) begin
      q_d = sum[Width-1:0];
      if (above || below) begin
        ovf_d    = 1'b1;
        sticky_d = 1'b1;
        if (Sat) begin
          q_d = above ? MaxVal[Width-1:0] : MinVal[Width-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign q_o          = q_q;
  assign ovf_o        = ovf_q;
  assign ovf_sticky_o = sticky_q;
  assign zero_o       = (q_q == '0);
  assign neg_o        = q_q[Width-1];

endmodule

// File: doc/signed_step_counter.md
# signed_step_counter

Parametrised registered signed up/down counter for the signed calculator datapath. It is the clocked successor to the combinational 6-bit decrementer. Each enabled cycle it adds or subtracts a programmable step to a two's-complement register, selecting wrap-around or saturation at compile time. It reports per-step overflow, sticky overflow, zero and sign status to the calculator control and display logic.

## Interface
- WIDTH, 6, register and step width in bits (≥2); q range −2^(WIDTH−1) … 2^(WIDTH−1)−1
- SAT, 0, overflow policy: 0 = wrap modulo 2^WIDTH, 1 = clamp to the most positive or most negative value
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-low reset
- en  input  1  step enable; one step per cycle while high
- load  input  1  synchronous parallel load of d
- d  input  WIDTH  signed load value
- up_dn  input  1  1 = q + step, 0 = q − step
- step  input  WIDTH  unsigned step magnitude, 0 … 2^WIDTH−1
- q  output  WIDTH  signed counter value (registered)
- ovf  output  1  one-cycle pulse: the last step left the signed range (registered)
- ovf_sticky  output  1  set by any ovf; cleared only by load or reset (registered)
- zero  output  1  q == 0 (combinational from q)
- neg  output  1  q[WIDTH−1] (combinational from q)

## Operation
- Reset (rst low, asynchronous): q = 0, ovf = 0, ovf_sticky = 0; zero therefore = 1 and neg = 0.
- Each rising edge with rst high is resolved in the following priority order.
- load = 1: q ← d, ovf ← 0, ovf_sticky ← 0. en, up_dn and step are ignored this cycle.
- load = 0, en = 1: compute r = sext(q) ± zext(step) in WIDTH+2 bits, signed.
  - r in range: q ← r[WIDTH−1:0], ovf ← 0.
  - r above max: ovf ← 1, ovf_sticky ← 1; q ← r[WIDTH−1:0] if SAT = 0, else q ← max.
  - r below min: ovf ← 1, ovf_sticky ← 1; q ← r[WIDTH−1:0] if SAT = 0, else q ← min.
- load = 0, en = 0: q and ovf_sticky hold; ovf ← 0.
- step = 0 with en = 1: q unchanged, ovf ← 0. Not an error.
- Steps larger than the signed range are legal: with SAT = 0 the result is plain modulo 2^WIDTH; with SAT = 1 it clamps.
- Only two states matter, reset and running. Running is entered on the first edge after rst is released. No other FSM.

## Timing
- Latency: inputs sampled at edge N; q and ovf are valid after edge N. zero and neg follow q combinationally in the same cycle.
- Throughput: one step per clock. No handshake; en is a level qualifier.
- ovf is high for exactly one cycle per overflowing step. Back-to-back overflowing steps keep it high on consecutive cycles.
- Asserting reset mid-operation clears all state immediately, without waiting for a clock edge. The first update after release happens on the first rising edge with rst high.
- Arithmetic path fits in one cycle: a WIDTH+2-bit adder/subtractor, range comparison and SAT mux.

## Test plan
- Reset: hold rst low, toggle clk → q = 0, zero = 1, neg = 0, ovf = 0, ovf_sticky = 0. Pulse rst low between edges mid-count → q = 0 immediately.
- Wrap up, WIDTH = 6, SAT = 0: load d = 31, then en = 1, up_dn = 1, step = 1 → q = −32 (6'b100000), ovf = 1 for one cycle, ovf_sticky = 1, neg = 1. Next step → q = −31, ovf = 0, ovf_sticky = 1.
- Wrap down, SAT = 0: load −32, en = 1, up_dn = 0, step = 1 → q = 31, ovf = 1. Load 5, step 63 down → q = 6 (−58 mod 64), ovf = 1.
- Saturate, SAT = 1: load 30, up, step 5 → q = 31, ovf = 1. Load −30, down, step 63 → q = −32, ovf = 1. Then up by 2 → q = −30, ovf = 0.
- Priority and holds: load = 1 and en = 1 with d = 7 → q = 7, ovf_sticky cleared. en = 0 for 3 cycles → q holds. step = 0 with en = 1 → q holds, ovf = 0. From q = 1, down step 1 → q = 0, zero = 1.
- Random compare: 10k cycles of random load/en/up_dn/step for WIDTH = 6 and WIDTH = 16, both SAT values, checked against a reference model of q, ovf and ovf_sticky.
